// File: rtl/lc3_pc_pkg.sv
// ---------------------------------------------------------------------------
// lc3_pc_pkg
//   Shared definitions for the LC-3 program-counter unit: the encodings of the
//   next-PC select field and the default PC/address width.
// ---------------------------------------------------------------------------
package lc3_pc_pkg;

   localparam int ADDR_W_DEFAULT = 16;

   // Next-PC source select, as driven by the control FSM on pc_sel.
   typedef enum logic [1:0] {
      PC_SEL_INC = 2'b00,   // PC + 1
      PC_SEL_BUS = 2'b01,   // datapath bus
      PC_SEL_EA  = 2'b10,   // effective address
      PC_SEL_VEC = 2'b11    // trap / interrupt vector
   } pc_sel_e;

endpackage : lc3_pc_pkg

// File: rtl/pc_ras_stack.sv
// ---------------------------------------------------------------------------
// pc_ras_stack
//   Circular return-address stack with a valid-entry count and sticky
//   overflow/underflow flags. A push onto a full stack overwrites the oldest
//   entry. A push and pop together on a non-empty stack replace the top entry.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   push_i, pop_i    stack operations for this cycle
//   err_clr_i        clear sticky flags (a same-cycle set wins)
//   push_data_i      value written on push
//   top_o            top-of-stack entry, 0 when empty
//   cnt_o            number of valid entries
//   full_o, empty_o  cnt_o == DEPTH / cnt_o == 0
//   ovf_o, unf_o     sticky overflow / underflow
// ---------------------------------------------------------------------------
module pc_ras_stack #(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     err_clr_i,
   input  logic [ADDR_W-1:0]        push_data_i,
   output logic [ADDR_W-1:0]        top_o,
   output logic [$clog2(DEPTH):0]   cnt_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic                     ovf_o,
   output logic                     unf_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] mem [DEPTH];

   // ptr_q is the next free slot; the top entry lives at ptr_q - 1. DEPTH is
   // a power of two, so pointer arithmetic wraps around the buffer for free.
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              wr_en;
   logic [PTR_W-1:0]  wr_idx;
   logic [PTR_W-1:0]  top_idx;
   logic              ovf_set;
   logic              unf_set;

   assign top_idx = ptr_q - PTR_W'(1);
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign top_o   = empty_o ? '0 : mem[top_idx];
   assign cnt_o   = cnt_q;
   assign ovf_o   = ovf_q;
   assign unf_o   = unf_q;

   // NOTE: every variable gets a default at the top of always_comb so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_idx  = ptr_q;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (push_i && pop_i && !empty_o) begin
         // Replace top in place: pointer and count unchanged.
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else begin
         if (push_i) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PTR_W'(1);
            if (full_o) ovf_set = 1'b1;   // oldest entry overwritten
            else        cnt_d   = cnt_q + CNT_W'(1);
         end
         // Here a pop is either alone, or paired with a push on an empty stack.
         if (pop_i) begin
            if (empty_o) begin
               unf_set = 1'b1;
            end else begin
               ptr_d = ptr_q - PTR_W'(1);
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      end
      ovf_d = ovf_set | (ovf_q & ~err_clr_i);
      unf_d = unf_set | (unf_q & ~err_clr_i);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // NOTE: the entry array is deliberately not reset; cnt_q = 0 marks every
   // entry invalid, and leaving storage unreset lets it map to plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= push_data_i;
   end

endmodule : pc_ras_stack

// File: rtl/pc_ras_unit.sv
// ---------------------------------------------------------------------------
// pc_ras_unit
//   LC-3 program counter with next-PC selection, bus gating of PC and PC-1,
//   and an optional return-address stack (RAS).
//
//   Build option: define PC_RAS_EN to include the return-address stack and
//   the pop-override of the next-PC mux. Without it the ras_* inputs are
//   ignored and the ras_* outputs are tied to their empty-stack values.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   bus, ea, vec             next-PC sources
//   ld_pc, pc_sel            load enable and source select (lc3_pc_pkg)
//   ras_push, ras_pop        stack push of reg_pc / pop (with ld_pc: load top)
//   err_clr                  clear sticky ras_ovf / ras_unf
//   gate_pc_en               drive pc
//   gate_pc_minus_1_en       drive pc_minus_one
//   reg_pc                   PC register
//   pc, pc_minus_one         gated PC / PC-1 (0 when not gated, bus is OR-ed)
//   ras_top, ras_cnt         top entry (0 when empty) / valid entry count
//   ras_full, ras_empty      stack full / empty
//   ras_ovf, ras_unf         sticky overflow / underflow
// ---------------------------------------------------------------------------
module pc_ras_unit
   import lc3_pc_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_W_DEFAULT,
   parameter int                RAS_DEPTH = 8,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_W-1:0]            bus,
   input  logic [ADDR_W-1:0]            ea,
   input  logic [ADDR_W-1:0]            vec,
   input  logic                         ld_pc,
   input  logic [1:0]                   pc_sel,
   input  logic                         ras_push,
   input  logic                         ras_pop,
   input  logic                         err_clr,
   input  logic                         gate_pc_en,
   input  logic                         gate_pc_minus_1_en,
   output logic [ADDR_W-1:0]            reg_pc,
   output logic [ADDR_W-1:0]            pc,
   output logic [ADDR_W-1:0]            pc_minus_one,
   output logic [ADDR_W-1:0]            ras_top,
   output logic [$clog2(RAS_DEPTH):0]   ras_cnt,
   output logic                         ras_full,
   output logic                         ras_empty,
   output logic                         ras_ovf,
   output logic                         ras_unf
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] sel_pc;
   logic              pop_hit;   // pop of a valid entry this cycle

`ifdef PC_RAS_EN
   pc_ras_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RAS_DEPTH)
   ) u_stack (
      .clk         (clk),
      .rst         (rst),
      .push_i      (ras_push),
      .pop_i       (ras_pop),
      .err_clr_i   (err_clr),
      .push_data_i (pc_q),       // return address = pre-update PC
      .top_o       (ras_top),
      .cnt_o       (ras_cnt),
      .full_o      (ras_full),
      .empty_o     (ras_empty),
      .ovf_o       (ras_ovf),
      .unf_o       (ras_unf)
   );
   assign pop_hit = ras_pop & ~ras_empty;
`else
   logic unused_ras_in;
   assign unused_ras_in = ^{ras_push, ras_pop, err_clr};
   assign ras_top   = '0;
   assign ras_cnt   = '0;
   assign ras_full  = 1'b0;
   assign ras_empty = 1'b1;
   assign ras_ovf   = 1'b0;
   assign ras_unf   = 1'b0;
   assign pop_hit   = 1'b0;
`endif

   always_comb begin
      sel_pc = pc_q + ADDR_W'(1);
      unique case (pc_sel_e'(pc_sel))
         PC_SEL_INC: sel_pc = pc_q + ADDR_W'(1);
         PC_SEL_BUS: sel_pc = bus;
         PC_SEL_EA:  sel_pc = ea;
         PC_SEL_VEC: sel_pc = vec;
         default:    sel_pc = pc_q + ADDR_W'(1);
      endcase
   end

   // A valid pop with ld_pc returns to the stacked address, overriding pc_sel.
   assign pc_d = !ld_pc  ? pc_q    :
                 pop_hit ? ras_top : sel_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_d;
   end

   assign reg_pc       = pc_q;
   assign pc           = gate_pc_en         ? pc_q                 : '0;
   assign pc_minus_one = gate_pc_minus_1_en ? pc_q - ADDR_W'(1)    : '0;

endmodule : pc_ras_unit

// File: tb/tb_pc_ras_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_ras_unit
//   Directed and randomized stimulus for pc_ras_unit, checked against a
//   queue-based reference model of the PC and return-address stack.
// ---------------------------------------------------------------------------
module tb_pc_ras_unit;

   localparam int          AW    = 16;
   localparam int          DEPTH = 8;
   localparam logic [15:0] RPC   = 16'h3000;
`ifdef PC_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   bus, ea, vec;
   logic          ld_pc;
   logic [1:0]    pc_sel;
   logic          ras_push, ras_pop, err_clr;
   logic          gate_pc_en, gate_pc_minus_1_en;
   logic [15:0]   reg_pc, pc, pc_minus_one, ras_top;
   logic [3:0]    ras_cnt;
   logic          ras_full, ras_empty, ras_ovf, ras_unf;

   pc_ras_unit #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .bus(bus), .ea(ea), .vec(vec),
      .ld_pc(ld_pc), .pc_sel(pc_sel), .ras_push(ras_push), .ras_pop(ras_pop),
      .err_clr(err_clr), .gate_pc_en(gate_pc_en),
      .gate_pc_minus_1_en(gate_pc_minus_1_en), .reg_pc(reg_pc), .pc(pc),
      .pc_minus_one(pc_minus_one), .ras_top(ras_top), .ras_cnt(ras_cnt),
      .ras_full(ras_full), .ras_empty(ras_empty), .ras_ovf(ras_ovf),
      .ras_unf(ras_unf)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: the stack is a queue, oldest entry at the front.
   logic [15:0] m_pc;
   logic [15:0] m_q[$];
   bit          m_ovf, m_unf;

   task automatic model_reset();
      m_pc = RPC;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic model_step();
      logic [15:0] src, old_top;
      int          n;
      bit          ovf_s, unf_s, pop_ok;
      n      = m_q.size();
      ovf_s  = 1'b0;
      unf_s  = 1'b0;
      old_top = (n > 0) ? m_q[n-1] : 16'h0;
      pop_ok = RAS_EN && ras_pop && (n > 0);
      case (pc_sel)
         2'd0: src = m_pc + 16'd1;
         2'd1: src = bus;
         2'd2: src = ea;
         default: src = vec;
      endcase
      if (RAS_EN) begin
         if (ras_push && ras_pop && n > 0) begin
            m_q[n-1] = m_pc;
         end else begin
            if (ras_push) begin
               if (n == DEPTH) begin
                  void'(m_q.pop_front());
                  ovf_s = 1'b1;
               end
               m_q.push_back(m_pc);
            end
            if (ras_pop) begin
               if (n == 0) unf_s = 1'b1;
               else        void'(m_q.pop_back());
            end
         end
         m_ovf = ovf_s | (m_ovf & ~err_clr);
         m_unf = unf_s | (m_unf & ~err_clr);
      end
      if (ld_pc) m_pc = pop_ok ? old_top : src;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int n;
      n = m_q.size();
      chk("reg_pc", 32'(reg_pc), 32'(m_pc));
      chk("pc", 32'(pc), gate_pc_en ? 32'(m_pc) : 32'h0);
      chk("pc_minus_one", 32'(pc_minus_one),
          gate_pc_minus_1_en ? 32'(16'(m_pc - 16'd1)) : 32'h0);
      chk("ras_top", 32'(ras_top), (n > 0) ? 32'(m_q[n-1]) : 32'h0);
      chk("ras_cnt", 32'(ras_cnt), 32'(n));
      chk("ras_full", 32'(ras_full), 32'(n == DEPTH));
      chk("ras_empty", 32'(ras_empty), 32'(n == 0));
      chk("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
      chk("ras_unf", 32'(ras_unf), 32'(m_unf));
   endtask

   // One clock: drive inputs, advance model and DUT together, compare.
   task automatic step(input bit ld, input logic [1:0] sel, input logic [15:0] b,
                       input bit push, input bit pop, input bit clr,
                       input bit gpc, input bit gpm);
      ld_pc = ld; pc_sel = sel; bus = b; ras_push = push; ras_pop = pop;
      err_clr = clr; gate_pc_en = gpc; gate_pc_minus_1_en = gpm;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      rst = 1'b1; bus = '0; ea = 16'h4000; vec = 16'h0025; ld_pc = 1'b0;
      pc_sel = 2'd0; ras_push = 1'b0; ras_pop = 1'b0; err_clr = 1'b0;
      gate_pc_en = 1'b1; gate_pc_minus_1_en = 1'b1;
      model_reset();
      #12;
      check_all();
      rst = 1'b0;

      // Increment from RESET_PC: 3001, 3002, 3003 (pc_minus_one 3002 last)
      for (int i = 0; i < 3; i++) step(1, 2'd0, 16'h0, 0, 0, 0, 1, 1);
      // Hold when ld_pc low, vec source
      step(0, 2'd3, 16'h0, 0, 0, 0, 1, 0);
      step(1, 2'd3, 16'h0, 0, 0, 0, 0, 1);
      // Wrap FFFF -> 0000, PC-1 of 0 is FFFF, then gates low
      step(1, 2'd1, 16'hFFFF, 0, 0, 0, 1, 1);
      step(1, 2'd0, 16'h0, 0, 0, 0, 1, 1);
      step(0, 2'd0, 16'h0, 0, 0, 0, 0, 0);

      // Call/return: push 3005, jump to ea 4000, pop back to 3005
      step(1, 2'd1, 16'h3005, 0, 0, 0, 1, 1);
      step(0, 2'd0, 16'h0, 1, 0, 0, 1, 1);
      step(1, 2'd2, 16'h0, 0, 0, 0, 1, 1);
      step(1, 2'd0, 16'h0, 0, 1, 0, 1, 1);

      // Nine pushes of 1..9 overflow a depth-8 stack
      for (int k = 1; k <= 9; k++) begin
         step(1, 2'd1, 16'(k), 0, 0, 0, 1, 1);
         step(0, 2'd0, 16'h0, 1, 0, 0, 1, 1);
      end
      // Eight returning pops (9..2), then underflow with bus source
      for (int k = 0; k < 8; k++) step(1, 2'd0, 16'h0, 0, 1, 0, 1, 1);
      step(1, 2'd1, 16'h1234, 0, 1, 0, 1, 1);
      step(0, 2'd0, 16'h0, 0, 0, 1, 1, 1);

      // Push+pop replace: stack holds A0, reg_pc 5000
      step(1, 2'd1, 16'h00A0, 0, 0, 0, 1, 1);
      step(1, 2'd1, 16'h5000, 1, 0, 0, 1, 1);
      step(1, 2'd0, 16'h0, 1, 1, 0, 1, 1);
      // Push+pop on empty stack after draining
      step(0, 2'd0, 16'h0, 0, 1, 0, 1, 1);
      step(1, 2'd2, 16'h0, 1, 1, 0, 1, 1);
      // Set wins over clear
      step(0, 2'd0, 16'h0, 0, 1, 0, 1, 1);
      step(0, 2'd0, 16'h0, 0, 1, 1, 1, 1);
      step(0, 2'd0, 16'h0, 0, 0, 1, 1, 1);

      // Asynchronous reset mid-cycle after three pushes
      for (int k = 0; k < 3; k++) step(1, 2'd0, 16'h0, 1, 0, 0, 1, 1);
      #3 rst = 1'b1;
      model_reset();
      #1 check_all();
      #1 rst = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         ea  = 16'($urandom);
         vec = 16'($urandom);
         step(bit'($urandom_range(0, 3) != 0), 2'($urandom), 16'($urandom),
              bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 2) == 0),
              bit'($urandom_range(0, 9) == 0), bit'($urandom), bit'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_pc_ras_unit
